audio_control: RTL and testbench

- Downstream consumer of the four channel `Timer[4:1]` pulses and `rstAudPhase` from the frequency-control stage.
- Holds the four AUDC registers (distortion, volume-only, volume).
- Each channel:
  - a tone flip-flop clocked by its Timer pulse and gated by the poly counter bits;
  - an optional high-pass flip-flop (ch1 filtered by ch3, ch2 filtered by ch4);
  - volume gating.
- Produces per-channel 4-bit levels and a registered 6-bit summed audio output for the DAC stage.

---
 rtl/audio_control.sv | 152 +++++++++++++++
 tb/tb_audio_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/audio_control.sv
// audio_control: POKEY-style per-channel audio output stage.
//
// Holds the four AUDC registers. Each channel has a tone flip-flop clocked by
// its Timer pulse and gated by the poly counters. Channels 1 and 2 also have an
// optional high-pass flip-flop, sampled by the Timer pulses of channels 3 and 4.
// The block produces per-channel volume levels and a registered 6-bit sum for
// the DAC stage.
//
// Optional feature macro: AUDIO_HPF_EN. When it is defined, the high-pass
// flip-flops h[2:1] are implemented. When it is undefined, h is constant 0 and
// the hpf1/hpf2 inputs are ignored.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    asynchronous active-high reset
//   enp                    phase enable; state advances only when high
//   D[7:0]                 CPU write data
//   Addr1w/3w/5w/7w        AUDC1..AUDC4 write strobes
//   Timer[3:0]             per-channel underflow pulses (bit0 = channel 1)
//   rstAudPhase            clears the tone and high-pass flip-flops
//   hpf1, hpf2             high-pass enables for channel 1 and channel 2
//   poly4, poly5, poly17   poly counter output bits
//   ChLvl1..ChLvl4         current channel levels
//   AudOut[5:0]            registered sum of the four levels
module audio_control #(
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enp,
    input  logic [7:0]       D,
    input  logic             Addr1w,
    input  logic             Addr3w,
    input  logic             Addr5w,
    input  logic             Addr7w,
    input  logic [3:0]       Timer,
    input  logic             rstAudPhase,
    input  logic             hpf1,
    input  logic             hpf2,
    input  logic             poly4,
    input  logic             poly5,
    input  logic             poly17,
    output logic [VOL_W-1:0] ChLvl1,
    output logic [VOL_W-1:0] ChLvl2,
    output logic [VOL_W-1:0] ChLvl3,
    output logic [VOL_W-1:0] ChLvl4,
    output logic [5:0]       AudOut
);

    logic [7:0]       audc_q [4];
    logic [7:0]       audc_d [4];
    logic [3:0]       t_q, t_d;
    logic [1:0]       h_q;
    logic [3:0]       wr;
    logic [3:0]       o;
    logic [VOL_W-1:0] lvl [4];
    logic [5:0]       aud_q, aud_d;

    assign wr = {Addr7w, Addr5w, Addr3w, Addr1w};

    // AUDC write and tone flip-flop next state
    always_comb begin
        t_d = t_q;
        for (int unsigned n = 0; n < 4; n++) begin
            audc_d[n] = audc_q[n];
            if (wr[n]) begin
                audc_d[n] = D;
            end
            if (Timer[n]) begin
                if (!(audc_q[n][7] | poly5)) begin
                    t_d[n] = t_q[n];
                end else if (audc_q[n][5]) begin
                    t_d[n] = ~t_q[n];
                end else if (audc_q[n][6]) begin
                    t_d[n] = poly4;
                end else begin
                    t_d[n] = poly17;
                end
            end
        end
        if (rstAudPhase) begin
            t_d = '0;
        end
    end

`ifdef AUDIO_HPF_EN
    logic [1:0] h_d;

    // The high-pass flip-flops sample the pre-edge t_q, so a Timer[1] pulse
    // and a Timer[3] pulse at the same edge give h[1] the old t[1].
    always_comb begin
        h_d = h_q;
        if (!hpf1) begin
            h_d[0] = 1'b0;
        end else if (Timer[2]) begin
            h_d[0] = t_q[0];
        end
        if (!hpf2) begin
            h_d[1] = 1'b0;
        end else if (Timer[3]) begin
            h_d[1] = t_q[1];
        end
        if (rstAudPhase) begin
            h_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
        end else if (enp) begin
            h_q <= h_d;
        end
    end
`else
    logic unused_hpf;
    assign unused_hpf = &{1'b0, hpf1, hpf2};
    assign h_q = '0;
`endif

    assign o = {t_q[3], t_q[2], t_q[1] ^ h_q[1], t_q[0] ^ h_q[0]};

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            lvl[n] = (audc_q[n][4] | o[n]) ? audc_q[n][VOL_W-1:0] : '0;
        end
        aud_d = 6'(lvl[0]) + 6'(lvl[1]) + 6'(lvl[2]) + 6'(lvl[3]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < 4; n++) begin
                audc_q[n] <= '0;
            end
            t_q   <= '0;
            aud_q <= '0;
        end else if (enp) begin
            for (int unsigned n = 0; n < 4; n++) begin
                audc_q[n] <= audc_d[n];
            end
            t_q   <= t_d;
            aud_q <= aud_d;
        end
    end

    assign ChLvl1 = lvl[0];
    assign ChLvl2 = lvl[1];
    assign ChLvl3 = lvl[2];
    assign ChLvl4 = lvl[3];
    assign AudOut = aud_q;

endmodule

// File: tb/tb_audio_control.sv
// Directed testbench for audio_control with hand-computed expected values.
module tb_audio_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       enp;
    logic [7:0] D;
    logic       Addr1w, Addr3w, Addr5w, Addr7w;
    logic [3:0] Timer;
    logic       rstAudPhase;
    logic       hpf1, hpf2;
    logic       poly4, poly5, poly17;
    logic [3:0] ChLvl1, ChLvl2, ChLvl3, ChLvl4;
    logic [5:0] AudOut;

    int checks = 0;
    int fails  = 0;

    audio_control #(.VOL_W(4)) dut (
        .clk(clk), .rst(rst), .enp(enp), .D(D),
        .Addr1w(Addr1w), .Addr3w(Addr3w), .Addr5w(Addr5w), .Addr7w(Addr7w),
        .Timer(Timer), .rstAudPhase(rstAudPhase), .hpf1(hpf1), .hpf2(hpf2),
        .poly4(poly4), .poly5(poly5), .poly17(poly17),
        .ChLvl1(ChLvl1), .ChLvl2(ChLvl2), .ChLvl3(ChLvl3), .ChLvl4(ChLvl4),
        .AudOut(AudOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given Timer/rstAudPhase, then sample 1 ns later.
    task automatic cyc(input logic [3:0] tmr, input logic rap);
        Timer = tmr;
        rstAudPhase = rap;
        @(posedge clk);
        #1;
        Timer = '0;
        rstAudPhase = 1'b0;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [7:0] data);
        {Addr7w, Addr5w, Addr3w, Addr1w} = sel;
        D = data;
        @(posedge clk);
        #1;
        {Addr7w, Addr5w, Addr3w, Addr1w} = '0;
        D = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enp = 1'b1; D = '0;
        {Addr7w, Addr5w, Addr3w, Addr1w} = '0;
        Timer = '0; rstAudPhase = 1'b0; hpf1 = 1'b0; hpf2 = 1'b0;
        poly4 = 1'b0; poly5 = 1'b0; poly17 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lvl1", ChLvl1, 0);
        chk("rst_lvl4", ChLvl4, 0);
        chk("rst_aud", AudOut, 0);
        rst = 1'b0;

        // Reset mid-operation
        wr(4'b0001, 8'hAF);
        repeat (5) cyc(4'b0001, 1'b0);
        chk("mid_lvl1", ChLvl1, 15);
        cyc(4'b0000, 1'b0);
        chk("mid_aud", AudOut, 15);
        rst = 1'b1;
        #2;
        chk("mid_rst_lvl1", ChLvl1, 0);
        chk("mid_rst_aud", AudOut, 0);
        rst = 1'b0;
        cyc(4'b0001, 1'b0);
        chk("post_rst_lvl1", ChLvl1, 0);
        cyc(4'b0000, 1'b0);
        chk("post_rst_aud", AudOut, 0);

        // Pure tone, toggling on every fourth enp edge
        wr(4'b0001, 8'hA8);
        cyc(4'b0001, 1'b0);
        chk("tone_p1_lvl", ChLvl1, 8);
        chk("tone_p1_aud_lag", AudOut, 0);
        cyc(4'b0000, 1'b0);
        chk("tone_p1_aud", AudOut, 8);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0001, 1'b0);
        chk("tone_p2_lvl", ChLvl1, 0);
        chk("tone_p2_aud_lag", AudOut, 8);
        cyc(4'b0000, 1'b0);
        chk("tone_p2_aud", AudOut, 0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0001, 1'b0);
        chk("tone_p3_lvl", ChLvl1, 8);
        // c7=0 with poly5=0 gates the tone off: t[1] holds at 1
        wr(4'b0001, 8'h28);
        cyc(4'b0001, 1'b0);
        chk("gate_hold1", ChLvl1, 8);
        cyc(4'b0001, 1'b0);
        chk("gate_hold2", ChLvl1, 8);
        poly5 = 1'b1;
        cyc(4'b0001, 1'b0);
        chk("gate_poly5_toggle", ChLvl1, 0);
        poly5 = 1'b0;

        // Volume-only
        do_reset();
        wr(4'b0010, 8'h1F);
        chk("volonly_lvl2", ChLvl2, 15);
        cyc(4'b0000, 1'b0);
        chk("volonly_aud", AudOut, 15);
        wr(4'b1111, 8'h1F);
        chk("volonly_all_lvl4", ChLvl4, 15);
        cyc(4'b0000, 1'b0);
        chk("volonly_all_aud", AudOut, 60);

        // Poly select
        do_reset();
        wr(4'b0100, 8'hC6);
        poly4 = 1'b1; cyc(4'b0100, 1'b0);
        chk("poly4_a", ChLvl3, 6);
        poly4 = 1'b0; cyc(4'b0100, 1'b0);
        chk("poly4_b", ChLvl3, 0);
        poly4 = 1'b1; cyc(4'b0100, 1'b0);
        chk("poly4_c", ChLvl3, 6);
        wr(4'b0100, 8'h86);
        poly4 = 1'b1; poly17 = 1'b0; cyc(4'b0100, 1'b0);
        chk("poly17_a", ChLvl3, 0);
        poly4 = 1'b0; poly17 = 1'b1; cyc(4'b0100, 1'b0);
        chk("poly17_b", ChLvl3, 6);
        poly17 = 1'b0; cyc(4'b0100, 1'b0);
        chk("poly17_c", ChLvl3, 0);

        // High-pass
        do_reset();
        hpf1 = 1'b1;
        wr(4'b0001, 8'hAF);
        cyc(4'b0101, 1'b0);
        chk("hp_same_edge", ChLvl1, 15);
        cyc(4'b0100, 1'b0);
`ifdef AUDIO_HPF_EN
        chk("hp_lone_t3", ChLvl1, 0);
        hpf1 = 1'b0;
        cyc(4'b0000, 1'b0);
        chk("hp_off_clear", ChLvl1, 15);
        cyc(4'b0100, 1'b0);
        chk("hp_off_t3", ChLvl1, 15);
`else
        chk("hp_ignored", ChLvl1, 15);
`endif
        hpf1 = 1'b0;

        // Resync priority over Timer pulses
        do_reset();
        wr(4'b1111, 8'hAF);
        cyc(4'b1111, 1'b0);
        chk("rs_pre_lvl4", ChLvl4, 15);
        cyc(4'b0000, 1'b0);
        chk("rs_pre_aud", AudOut, 60);
        cyc(4'b1111, 1'b1);
        chk("rs_lvl1", ChLvl1, 0);
        chk("rs_lvl2", ChLvl2, 0);
        chk("rs_lvl3", ChLvl3, 0);
        chk("rs_lvl4", ChLvl4, 0);
        chk("rs_aud_lag", AudOut, 60);
        cyc(4'b0000, 1'b0);
        chk("rs_aud", AudOut, 0);
        cyc(4'b0001, 1'b0);
        chk("rs_audc_kept", ChLvl1, 15);

        // enp=0: Timer pulses and writes are ignored
        enp = 1'b0;
        cyc(4'b0001, 1'b0);
        chk("enp0_timer", ChLvl1, 15);
        wr(4'b0010, 8'h1F);
        chk("enp0_write", ChLvl2, 0);
        enp = 1'b1;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
